// File: rtl/step_ce_gen_pkg.sv
// Shared definitions for the step/auto count-enable generator:
// debounce state encodings and a counter-width helper.
package step_ce_gen_pkg;

  // Debounce FSM states. The two IDLE states hold an accepted level.
  // The two WAIT states time a candidate level before accepting it.
  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b10,
    WAIT_LO = 2'b11
  } deb_state_t;

  // Bits needed to hold values 0..n-1. Always at least one bit, so that a
  // divide-by-one prescaler still has a real (constant-zero) register.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    if (n <= 1) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, 4-state debounce FSM with a
// stability counter, registered debounced level and a one-cycle press strobe.
// The strobe is combinational. It is high during the cycle whose closing edge
// accepts a press, so a register fed by it rises together with lvl.
module btn_debounce
  import step_ce_gen_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN,
  output logic lvl,
  output logic press
);

  // dcnt counts stable samples seen so far, from 1 up to DEB_CYCLES.
  localparam int unsigned     DW   = cnt_width(DEB_CYCLES + 1);
  localparam logic [DW-1:0]   DMAX = DW'(DEB_CYCLES);
  localparam logic [DW-1:0]   DONE = DW'(1);

  logic            btn_m;
  logic            btn_s;
  deb_state_t      state_q;
  deb_state_t      state_d;
  logic [DW-1:0]   dcnt_q;
  logic [DW-1:0]   dcnt_d;
  logic            lvl_d;

  // Two-stage synchronizer for the raw, bouncing button input.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= BTN;
      btn_s <= btn_m;
    end
  end

  // Debounce state, stability counter and accepted level registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE_LO;
      dcnt_q  <= '0;
      lvl     <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      lvl     <= lvl_d;
    end
  end

  // Next-state logic. A WAIT state falls back to its IDLE state on any
  // glitch. It accepts once DEB_CYCLES consecutive samples agree.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    lvl_d   = lvl;
    press   = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        if (btn_s) begin
          state_d = WAIT_HI;
          dcnt_d  = DONE;
        end
      end
      WAIT_HI: begin
        if (!btn_s) begin
          state_d = IDLE_LO;
          dcnt_d  = '0;
        end else if (dcnt_q >= DMAX) begin
          state_d = IDLE_HI;
          dcnt_d  = '0;
          lvl_d   = 1'b1;
          press   = 1'b1;
        end else begin
          dcnt_d  = dcnt_q + DONE;
        end
      end
      IDLE_HI: begin
        if (!btn_s) begin
          state_d = WAIT_LO;
          dcnt_d  = DONE;
        end
      end
      WAIT_LO: begin
        if (btn_s) begin
          state_d = IDLE_HI;
          dcnt_d  = '0;
        end else if (dcnt_q >= DMAX) begin
          state_d = IDLE_LO;
          dcnt_d  = '0;
          lvl_d   = 1'b0;
        end else begin
          dcnt_d  = dcnt_q + DONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        dcnt_d  = '0;
        lvl_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/step_ce_gen.sv
// Count-enable source for the e74FSM counter.
// In step mode it emits one CE per debounced button press. In auto mode it
// emits a CE once every DIV clocks. CE and BTN_LVL are both registered.
module step_ce_gen
  import step_ce_gen_pkg::*;
#(
  parameter int unsigned DIV        = 50_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN,
  input  logic AUTO,
  output logic CE,
  output logic BTN_LVL
);

  localparam int unsigned   PW   = cnt_width(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [PW-1:0] PONE = PW'(1);

  logic          auto_m;
  logic          auto_s;
  logic [PW-1:0] pcnt;
  logic          tick;
  logic          press;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .CLK   (CLK),
    .RESET (RESET),
    .BTN   (BTN),
    .lvl   (BTN_LVL),
    .press (press)
  );

  // Two-stage synchronizer for the mode slide switch.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      auto_m <= 1'b0;
      auto_s <= 1'b0;
    end else begin
      auto_m <= AUTO;
      auto_s <= auto_m;
    end
  end

  // The prescaler fires on the last count of each DIV-cycle period.
  assign tick = auto_s && (pcnt == PMAX);

  // Prescaler: runs only in auto mode. It is cleared while in step mode, so
  // a partial count left over from auto mode can never produce a late tick.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pcnt <= '0;
    end else if (!auto_s || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PONE;
    end
  end

  // CE mux register. Presses accepted in auto mode are dropped here, while
  // the debouncer keeps tracking the button for BTN_LVL.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      CE <= 1'b0;
    end else begin
      CE <= auto_s ? tick : press;
    end
  end

endmodule
